// File: rtl/buffer_client_scheduler.sv
// Round-robin GET/PUT scheduler sharing one buffer_arbiter among clients.
// Counts buffers held per client and withholds GETs at the hold limit.

module bcs_channel #(
  parameter int N  = 4,
  parameter int GW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req_i,
  input  logic [N-1:0]  mask_i,
  input  logic          dn_ack_i,
  output logic          dn_req_o,
  output logic          start_o,
  output logic [GW-1:0] pick_o,
  output logic          done_o,
  output logic [GW-1:0] gnt_o,
  output logic [N-1:0]  ack_o
);

  typedef enum logic [1:0] {IDLE, REQ, RTZ} state_e;

  state_e        state_q, state_d;
  logic [GW-1:0] ptr_q, ptr_d;
  logic [GW-1:0] gnt_q, gnt_d;
  logic [N-1:0]  ack_q, ack_d;
  logic [N-1:0]  elig;
  logic          pick_vld;
  logic [GW-1:0] pick;

  // first eligible client after the last grant, wrapping
  always_comb begin
    elig     = req_i & mask_i;
    pick_vld = 1'b0;
    pick     = '0;
    for (int i = 1; i <= N; i++) begin
      if (!pick_vld && elig[(int'(ptr_q) + i) % N]) begin
        pick_vld = 1'b1;
        pick     = GW'((int'(ptr_q) + i) % N);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    ack_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          gnt_d   = pick;
          state_d = REQ;
        end
      end
      REQ: begin
        if (dn_ack_i) begin
          ack_d[gnt_q] = 1'b1;
          ptr_d        = gnt_q;
          state_d      = RTZ;
        end
      end
      RTZ: begin
        if (!req_i[gnt_q] && !dn_ack_i)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= GW'(N - 1);
      gnt_q   <= '0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
    end
  end

  assign dn_req_o = (state_q == REQ);
  assign start_o  = (state_q == IDLE) && pick_vld;
  assign pick_o   = pick;
  assign done_o   = (state_q == REQ) && dn_ack_i;
  assign gnt_o    = gnt_q;
  assign ack_o    = ack_q;

endmodule

module buffer_client_scheduler #(
  parameter int C_NUM_CLIENTS = 4,
  parameter int C_DATA_WIDTH  = 32,
  parameter int C_MAX_HELD    = 4,
  localparam int N  = C_NUM_CLIENTS,
  localparam int W  = C_DATA_WIDTH,
  localparam int GW = $clog2(C_NUM_CLIENTS),
  localparam int CW = $clog2(C_MAX_HELD + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    cl_get_req_i,
  output logic [N-1:0]    cl_get_ack_o,
  output logic [W-1:0]    cl_get_data_o,
  output logic            cl_get_ovf_o,
  input  logic [N-1:0]    cl_put_req_i,
  input  logic [N*W-1:0]  cl_put_data_i,
  output logic [N-1:0]    cl_put_ack_o,
  output logic            dn_get_req_o,
  input  logic            dn_get_ack_i,
  input  logic [W-1:0]    dn_get_data_i,
  input  logic            dn_get_ovf_i,
  output logic            dn_put_req_o,
  output logic [W-1:0]    dn_put_data_o,
  input  logic            dn_put_ack_i,
  output logic [N*CW-1:0] held_cnt_o,
  output logic [N-1:0]    put_err_o,
  input  logic [N-1:0]    clr_put_err_i
);

  logic [N-1:0][CW-1:0] held_q, held_d;
  logic [N-1:0]         err_q, err_d;
  logic [N-1:0]         get_mask, inc_v, dec_v;
  logic [W-1:0]         get_data_q, put_data_q;
  logic                 get_ovf_q;
  logic                 get_start, get_done, put_start, put_done;
  logic [GW-1:0]        get_pick, get_gnt, put_pick, put_gnt;
  logic                 unused_get;

  assign unused_get = ^{get_start, get_pick};

  always_comb begin
    for (int k = 0; k < N; k++)
      get_mask[k] = (held_q[k] != CW'(C_MAX_HELD));
  end

  bcs_channel #(.N(N), .GW(GW)) u_get (
    .clk(clk), .rst(rst),
    .req_i(cl_get_req_i), .mask_i(get_mask),
    .dn_ack_i(dn_get_ack_i), .dn_req_o(dn_get_req_o),
    .start_o(get_start), .pick_o(get_pick),
    .done_o(get_done), .gnt_o(get_gnt),
    .ack_o(cl_get_ack_o)
  );

  bcs_channel #(.N(N), .GW(GW)) u_put (
    .clk(clk), .rst(rst),
    .req_i(cl_put_req_i), .mask_i({N{1'b1}}),
    .dn_ack_i(dn_put_ack_i), .dn_req_o(dn_put_req_o),
    .start_o(put_start), .pick_o(put_pick),
    .done_o(put_done), .gnt_o(put_gnt),
    .ack_o(cl_put_ack_o)
  );

  always_comb begin
    inc_v          = '0;
    dec_v          = '0;
    inc_v[get_gnt] = get_done & ~dn_get_ovf_i;
    dec_v[put_gnt] = put_done;
  end

  // a PUT on an empty count flags an error instead of decrementing
  always_comb begin
    held_d = held_q;
    err_d  = err_q & ~clr_put_err_i;
    for (int k = 0; k < N; k++) begin
      if (dec_v[k] && held_q[k] == '0)
        err_d[k] = 1'b1;
      if (inc_v[k] && !(dec_v[k] && held_q[k] != '0))
        held_d[k] = held_q[k] + CW'(1);
      else if (!inc_v[k] && dec_v[k] && held_q[k] != '0)
        held_d[k] = held_q[k] - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      held_q     <= '0;
      err_q      <= '0;
      get_data_q <= '0;
      get_ovf_q  <= 1'b0;
      put_data_q <= '0;
    end else begin
      held_q    <= held_d;
      err_q     <= err_d;
      get_ovf_q <= get_done & dn_get_ovf_i;
      if (get_done)
        get_data_q <= dn_get_data_i;
      if (put_start)
        put_data_q <= cl_put_data_i[int'(put_pick)*W +: W];
    end
  end

  assign cl_get_data_o = get_data_q;
  assign cl_get_ovf_o  = get_ovf_q;
  assign dn_put_data_o = put_data_q;
  assign held_cnt_o    = held_q;
  assign put_err_o     = err_q;

endmodule

// File: tb/tb_buffer_client_scheduler.sv
// Bench for buffer_client_scheduler: directed scenarios plus a
// randomized run against a transaction-level round-robin model.

module tb_buffer_client_scheduler;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int MH = 4;
  localparam int CW = $clog2(MH + 1);

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0]    cl_get_req_i, cl_get_ack_o;
  logic [N-1:0]    cl_put_req_i, cl_put_ack_o;
  logic [N-1:0]    put_err_o, clr_put_err_i;
  logic [W-1:0]    cl_get_data_o, dn_get_data_i, dn_put_data_o;
  logic            cl_get_ovf_o, dn_get_req_o, dn_get_ack_i;
  logic            dn_get_ovf_i, dn_put_req_o, dn_put_ack_i;
  logic [N*W-1:0]  cl_put_data_i;
  logic [N*CW-1:0] held_cnt_o;

  int n_chk = 0;
  int n_pass = 0;

  logic [N-1:0] gack, pack, lperr;
  logic [W-1:0] lgd, pdn;
  logic         lgo;

  buffer_client_scheduler #(
    .C_NUM_CLIENTS(N), .C_DATA_WIDTH(W), .C_MAX_HELD(MH)
  ) dut (
    .clk(clk), .rst(rst),
    .cl_get_req_i(cl_get_req_i), .cl_get_ack_o(cl_get_ack_o),
    .cl_get_data_o(cl_get_data_o), .cl_get_ovf_o(cl_get_ovf_o),
    .cl_put_req_i(cl_put_req_i), .cl_put_data_i(cl_put_data_i),
    .cl_put_ack_o(cl_put_ack_o),
    .dn_get_req_o(dn_get_req_o), .dn_get_ack_i(dn_get_ack_i),
    .dn_get_data_i(dn_get_data_i), .dn_get_ovf_i(dn_get_ovf_i),
    .dn_put_req_o(dn_put_req_o), .dn_put_data_o(dn_put_data_o),
    .dn_put_ack_i(dn_put_ack_i),
    .held_cnt_o(held_cnt_o), .put_err_o(put_err_o),
    .clr_put_err_i(clr_put_err_i)
  );

  always #5 clk = ~clk;

  function automatic int held(input int k);
    return int'(held_cnt_o[k*CW +: CW]);
  endfunction

  function automatic int rr_pick(input logic [N-1:0] e, input int last);
    for (int i = 1; i <= N; i++)
      if (e[(last + i) % N]) return (last + i) % N;
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    cl_get_req_i  = '0;
    cl_put_req_i  = '0;
    cl_put_data_i = '0;
    clr_put_err_i = '0;
    dn_get_ack_i  = 1'b0;
    dn_get_data_i = '0;
    dn_get_ovf_i  = 1'b0;
    dn_put_ack_i  = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // one cycle with an always-ready downstream and clients dropping on ack
  task automatic cyc();
    step();
    gack = cl_get_ack_o;
    pack = cl_put_ack_o;
    if (gack != 0) begin
      lgd = cl_get_data_o;
      lgo = cl_get_ovf_o;
    end
    if (pack != 0) lperr = put_err_o;
    if (dn_put_req_o) pdn = dn_put_data_o;
    dn_get_ack_i = dn_get_req_o;
    dn_put_ack_i = dn_put_req_o;
    cl_get_req_i = cl_get_req_i & ~gack;
    cl_put_req_i = cl_put_req_i & ~pack;
  endtask

  task automatic wait_ack(input bit put, input int k, input int lim,
                          output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim && !ok; i++) begin
      cyc();
      if (put ? pack[k] : gack[k]) ok = 1'b1;
    end
    if (ok) cyc();
  endtask

  task automatic test_reset();
    logic [N-1:0] first_g, first_p;
    clear_inputs();
    cl_get_req_i = '1;
    cl_put_req_i = '1;
    dn_get_ack_i = 1'b1;
    dn_put_ack_i = 1'b1;
    rst = 1'b1;
    step();
    step();
    n_chk++;
    if ({dn_get_req_o, dn_put_req_o, cl_get_ack_o, cl_put_ack_o,
         cl_get_ovf_o} !== '0)
      $display("FAIL reset_ctl: got %b want 0",
        {dn_get_req_o, dn_put_req_o, cl_get_ack_o, cl_put_ack_o,
         cl_get_ovf_o});
    else n_pass++;
    n_chk++;
    if ({held_cnt_o, put_err_o, cl_get_data_o, dn_put_data_o} !== '0)
      $display("FAIL reset_data: held %h err %b gd %h pd %h want 0",
        held_cnt_o, put_err_o, cl_get_data_o, dn_put_data_o);
    else n_pass++;
    dn_get_ack_i = 1'b0;
    dn_put_ack_i = 1'b0;
    rst = 1'b0;
    first_g = '0;
    first_p = '0;
    for (int i = 0; i < 10 && first_g == 0; i++) begin
      cyc();
      first_g = gack;
      first_p = pack;
    end
    n_chk++;
    if (first_g !== 4'b0001 || first_p !== 4'b0001)
      $display("FAIL reset_prio: get %b put %b want 0001",
        first_g, first_p);
    else n_pass++;
  endtask

  task automatic test_single_get();
    do_reset();
    cl_get_req_i  = 4'b0100;
    dn_get_data_i = 32'h7;
    for (int c = 1; c <= 5; c++) begin
      step();
      n_chk++;
      if (dn_get_req_o !== 1'b1 || cl_get_ack_o !== '0)
        $display("FAIL single_req c%0d: req %b ack %b want 1 0000",
          c, dn_get_req_o, cl_get_ack_o);
      else n_pass++;
      if (c == 5) dn_get_ack_i = 1'b1;
    end
    step();
    n_chk++;
    if (cl_get_ack_o !== 4'b0100 || cl_get_data_o !== 32'h7 ||
        dn_get_req_o !== 1'b0 || cl_get_ovf_o !== 1'b0)
      $display("FAIL single_ack: ack %b data %h req %b ovf %b want 0100 7 0 0",
        cl_get_ack_o, cl_get_data_o, dn_get_req_o, cl_get_ovf_o);
    else n_pass++;
    n_chk++;
    if (held(2) != 1)
      $display("FAIL single_held: got %0d want 1", held(2));
    else n_pass++;
    cl_get_req_i = '0;
    dn_get_ack_i = 1'b0;
    step();
    n_chk++;
    if (cl_get_ack_o !== '0)
      $display("FAIL single_pulse: got %b want 0000", cl_get_ack_o);
    else n_pass++;
  endtask

  task automatic test_rr();
    int order[$];
    int last_t, t;
    int exp_ord[5] = '{0, 1, 2, 3, 0};
    do_reset();
    cl_get_req_i = '1;
    last_t = -100;
    t = 0;
    while (t < 80 && order.size() < 5) begin
      cyc();
      t++;
      if (gack != 0) begin
        for (int k = 0; k < N; k++) if (gack[k]) order.push_back(k);
        if (order.size() > 1) begin
          n_chk++;
          if (t - last_t < 3)
            $display("FAIL rr_spacing: got %0d want >=3", t - last_t);
          else n_pass++;
        end
        last_t = t;
      end else begin
        cl_get_req_i = '1;
      end
    end
    n_chk++;
    if (order.size() != 5)
      $display("FAIL rr_count: got %0d want 5", order.size());
    else n_pass++;
    for (int i = 0; i < 5 && i < order.size(); i++) begin
      n_chk++;
      if (order[i] != exp_ord[i])
        $display("FAIL rr_order%0d: got %0d want %0d",
          i, order[i], exp_ord[i]);
      else n_pass++;
    end
  endtask

  task automatic test_max_held();
    bit ok, got1, got3;
    do_reset();
    for (int i = 0; i < MH; i++) begin
      cl_get_req_i[1] = 1'b1;
      dn_get_data_i   = 32'(i + 16);
      wait_ack(1'b0, 1, 10, ok);
      n_chk++;
      if (!ok) $display("FAIL max_get%0d: got no ack want ack", i);
      else n_pass++;
    end
    n_chk++;
    if (held(1) != MH)
      $display("FAIL max_full: got %0d want %0d", held(1), MH);
    else n_pass++;
    cl_get_req_i[1] = 1'b1;
    cl_get_req_i[3] = 1'b1;
    got1 = 1'b0;
    got3 = 1'b0;
    for (int i = 0; i < 15; i++) begin
      cyc();
      got1 |= gack[1];
      got3 |= gack[3];
    end
    n_chk++;
    if (got1 || !got3)
      $display("FAIL max_block: c1 %b c3 %b want 0 1", got1, got3);
    else n_pass++;
    n_chk++;
    if (held(1) != MH || held(3) != 1)
      $display("FAIL max_counts: c1 %0d c3 %0d want %0d 1",
        held(1), held(3), MH);
    else n_pass++;
    cl_put_req_i[1]          = 1'b1;
    cl_put_data_i[1*W +: W]  = 32'h11;
    wait_ack(1'b1, 1, 10, ok);
    n_chk++;
    if (!ok) $display("FAIL max_put: got no ack want ack");
    else n_pass++;
    wait_ack(1'b0, 1, 10, ok);
    n_chk++;
    if (!ok || held(1) != MH)
      $display("FAIL max_resume: ack %b held %0d want 1 %0d",
        ok, held(1), MH);
    else n_pass++;
  endtask

  task automatic test_ovf();
    bit ok;
    do_reset();
    dn_get_ovf_i    = 1'b1;
    cl_get_req_i[2] = 1'b1;
    wait_ack(1'b0, 2, 10, ok);
    n_chk++;
    if (!ok || lgo !== 1'b1 || held(2) != 0)
      $display("FAIL ovf_set: ack %b ovf %b held %0d want 1 1 0",
        ok, lgo, held(2));
    else n_pass++;
    dn_get_ovf_i    = 1'b0;
    cl_get_req_i[2] = 1'b1;
    wait_ack(1'b0, 2, 10, ok);
    n_chk++;
    if (!ok || lgo !== 1'b0 || held(2) != 1)
      $display("FAIL ovf_clr: ack %b ovf %b held %0d want 1 0 1",
        ok, lgo, held(2));
    else n_pass++;
  endtask

  task automatic test_put_err();
    bit ok;
    do_reset();
    cl_put_req_i[0]         = 1'b1;
    cl_put_data_i[0*W +: W] = 32'h55;
    wait_ack(1'b1, 0, 10, ok);
    n_chk++;
    if (!ok || pdn !== 32'h55)
      $display("FAIL perr_fwd: ack %b data %h want 1 55", ok, pdn);
    else n_pass++;
    cyc();
    cyc();
    n_chk++;
    if (put_err_o !== 4'b0001 || held(0) != 0)
      $display("FAIL perr_sticky: err %b held %0d want 0001 0",
        put_err_o, held(0));
    else n_pass++;
    clr_put_err_i = 4'b0001;
    cyc();
    clr_put_err_i = '0;
    n_chk++;
    if (put_err_o !== '0)
      $display("FAIL perr_clr: got %b want 0000", put_err_o);
    else n_pass++;
    clr_put_err_i   = 4'b0001;
    cl_put_req_i[0] = 1'b1;
    wait_ack(1'b1, 0, 10, ok);
    clr_put_err_i = '0;
    n_chk++;
    if (!ok || lperr !== 4'b0001)
      $display("FAIL perr_setwins: ack %b err %b want 1 0001", ok, lperr);
    else n_pass++;
  endtask

  task automatic test_same_cycle();
    bit ok, same;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      cl_get_req_i[3] = 1'b1;
      wait_ack(1'b0, 3, 10, ok);
    end
    n_chk++;
    if (held(3) != 2)
      $display("FAIL same_pre: got %0d want 2", held(3));
    else n_pass++;
    cl_get_req_i[3]         = 1'b1;
    cl_put_req_i[3]         = 1'b1;
    cl_put_data_i[3*W +: W] = 32'h33;
    same = 1'b0;
    ok   = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      cyc();
      if (gack[3] || pack[3]) begin
        ok   = 1'b1;
        same = gack[3] && pack[3];
      end
    end
    n_chk++;
    if (!same || held(3) != 2)
      $display("FAIL same_net: same %b held %0d want 1 2", same, held(3));
    else n_pass++;
  endtask

  task automatic test_rst_mid();
    do_reset();
    cl_get_req_i  = 4'b0001;
    cl_put_req_i  = 4'b0010;
    cl_put_data_i = {N{32'hA5A5_5A5A}};
    step();
    n_chk++;
    if (dn_get_req_o !== 1'b1 || dn_put_req_o !== 1'b1)
      $display("FAIL rstmid_busy: get %b put %b want 1 1",
        dn_get_req_o, dn_put_req_o);
    else n_pass++;
    rst = 1'b1;
    step();
    n_chk++;
    if ({dn_get_req_o, dn_put_req_o, cl_get_ack_o, cl_put_ack_o,
         cl_get_ovf_o, put_err_o, dn_put_data_o, held_cnt_o} !== '0)
      $display("FAIL rstmid_out: req %b%b dpd %h want 0",
        dn_get_req_o, dn_put_req_o, dn_put_data_o);
    else n_pass++;
    rst = 1'b0;
    clear_inputs();
  endtask

  task automatic test_random();
    int gp = N - 1;
    int pp = N - 1;
    int eg = -1;
    int ep = -1;
    int ng = 0;
    int np = 0;
    int mh[N];
    int hb[N];
    logic [N-1:0] me, setv, mask, gh, ph, ev;
    logic [N*CW-1:0] hexp;
    logic [W-1:0] pd[N];
    bit pdg, pdp;
    do_reset();
    for (int k = 0; k < N; k++) begin
      mh[k] = 0;
      pd[k] = '0;
    end
    me  = '0;
    pdg = 1'b0;
    pdp = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      step();
      for (int k = 0; k < N; k++) mask[k] = (mh[k] < MH);
      if (dn_get_req_o && !pdg) eg = rr_pick(cl_get_req_i & mask, gp);
      if (dn_put_req_o && !pdp) begin
        ep = rr_pick(cl_put_req_i, pp);
        n_chk++;
        if (ep < 0 || dn_put_data_o !== pd[ep])
          $display("FAIL rnd_putdata t%0d: got %h client %0d",
            t, dn_put_data_o, ep);
        else n_pass++;
      end
      gh   = cl_get_ack_o;
      ph   = cl_put_ack_o;
      setv = '0;
      hb   = mh;
      if (gh != 0) begin
        ev = '0;
        if (eg >= 0) ev[eg] = 1'b1;
        n_chk++;
        if ({gh, cl_get_data_o, cl_get_ovf_o} !==
            {ev, dn_get_data_i, dn_get_ovf_i})
          $display("FAIL rnd_get t%0d: ack %b d %h o %b want %b %h %b",
            t, gh, cl_get_data_o, cl_get_ovf_o,
            ev, dn_get_data_i, dn_get_ovf_i);
        else n_pass++;
        ng++;
        if (eg >= 0) begin
          gp = eg;
          if (!dn_get_ovf_i) mh[eg]++;
        end
        eg = -1;
      end
      if (ph != 0) begin
        ev = '0;
        if (ep >= 0) ev[ep] = 1'b1;
        n_chk++;
        if (ph !== ev)
          $display("FAIL rnd_put t%0d: ack %b want %b", t, ph, ev);
        else n_pass++;
        np++;
        if (ep >= 0) begin
          pp = ep;
          if (hb[ep] == 0) setv[ep] = 1'b1;
          else mh[ep]--;
        end
        ep = -1;
      end
      me = (me & ~clr_put_err_i) | setv;
      for (int k = 0; k < N; k++) hexp[k*CW +: CW] = CW'(mh[k]);
      n_chk++;
      if (held_cnt_o !== hexp || put_err_o !== me)
        $display("FAIL rnd_state t%0d: held %h err %b want %h %b",
          t, held_cnt_o, put_err_o, hexp, me);
      else n_pass++;
      pdg = dn_get_req_o;
      pdp = dn_put_req_o;
      if (!dn_get_req_o) dn_get_ack_i = 1'b0;
      else if (!dn_get_ack_i && $urandom_range(2) == 0) begin
        dn_get_ack_i  = 1'b1;
        dn_get_data_i = $urandom;
        dn_get_ovf_i  = ($urandom_range(4) == 0);
      end
      if (!dn_put_req_o) dn_put_ack_i = 1'b0;
      else if (!dn_put_ack_i && $urandom_range(2) == 0)
        dn_put_ack_i = 1'b1;
      for (int k = 0; k < N; k++) begin
        if (gh[k]) cl_get_req_i[k] = 1'b0;
        else if (!cl_get_req_i[k] && $urandom_range(3) == 0)
          cl_get_req_i[k] = 1'b1;
        if (ph[k]) cl_put_req_i[k] = 1'b0;
        else if (!cl_put_req_i[k] && $urandom_range(5) == 0) begin
          cl_put_req_i[k]         = 1'b1;
          pd[k]                   = $urandom;
          cl_put_data_i[k*W +: W] = pd[k];
        end
      end
      clr_put_err_i = ($urandom_range(15) == 0) ? N'($urandom) : '0;
    end
    n_chk++;
    if (ng < 20 || np < 20)
      $display("FAIL rnd_progress: gets %0d puts %0d want >=20 each",
        ng, np);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    gack  = '0;
    pack  = '0;
    lperr = '0;
    lgd   = '0;
    lgo   = 1'b0;
    pdn   = '0;
    test_reset();
    test_single_get();
    test_rr();
    test_max_held();
    test_ovf();
    test_put_err();
    test_same_cycle();
    test_rst_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
